// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: time-multiplexed LED matrix column scanner with blanking, double buffering and blink
// Ports:
//   clock, reset_n     system clock (rising edge), asynchronous active-low reset
//   enable             scanning runs while high; low parks the scanner in IDLE
//   blink_en           blink request, sampled at frame boundaries
//   image[COLS*ROWS]   pattern, column k at [k*ROWS +: ROWS], active-low
//   rows[ROWS]         registered row drive, active-low
//   cols[COLS]         registered one-hot column enable, zero while blanked
//   frame_done         one-clock pulse after the last column of a frame
module matrix_column_scanner #(
  parameter int COLS         = 5,
  parameter int ROWS         = 7,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 blink_en,
  input  logic [COLS*ROWS-1:0] image,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 frame_done
);
  localparam int MAXC = SCAN_DIV > BLANK_CYCLES ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(COLS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] C_LAST = IW'(COLS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [COLS*ROWS-1:0] shadow, shadow_nxt;
  logic                 phase, phase_nxt;
  logic [FW-1:0]        fcnt, fcnt_nxt;
  logic                 done_nxt;
  logic [ROWS-1:0]      rows_nxt;
  logic [COLS-1:0]      cols_nxt;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    phase_nxt  = phase;
    fcnt_nxt   = fcnt;
    done_nxt   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = BLANK;
          idx_nxt    = '0;
          cnt_nxt    = '0;
          shadow_nxt = image;
        end
        BLANK: begin
          state_nxt = cnt == B_LAST ? DRIVE : BLANK;
          cnt_nxt   = cnt == B_LAST ? '0 : cnt + 1'b1;
        end
        DRIVE: begin
          cnt_nxt = cnt == S_LAST ? '0 : cnt + 1'b1;
          if (cnt == S_LAST) begin
            state_nxt = BLANK;
            idx_nxt   = idx == C_LAST ? '0 : idx + 1'b1;
            if (idx == C_LAST) begin
              // Frame boundary: reload the shadow buffer and advance blink state.
              done_nxt   = 1'b1;
              shadow_nxt = image;
              phase_nxt  = !blink_en ? 1'b1 : (fcnt == F_LAST ? !phase : phase);
              fcnt_nxt   = (!blink_en || fcnt == F_LAST) ? '0 : fcnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Outputs are derived from the next state so they change on the same edge as the state.
    cols_nxt = state_nxt == DRIVE ? COLS'(1) << idx_nxt : '0;
    rows_nxt = (state_nxt == DRIVE && phase_nxt) ? shadow_nxt[idx_nxt*ROWS +: ROWS] : '1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '1;
      phase      <= 1'b1;
      fcnt       <= '0;
      rows       <= '1;
      cols       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      phase      <= phase_nxt;
      fcnt       <= fcnt_nxt;
      rows       <= rows_nxt;
      cols       <= cols_nxt;
      frame_done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner: directed vector bench for matrix_column_scanner (COLS=5, ROWS=7, SCAN_DIV=4, BLANK_CYCLES=2, BLINK_FRAMES=2)
module tb_matrix_column_scanner;
  localparam logic [6:0] PAT   = 7'b1111110;
  localparam logic [12:0] BLNK = {5'b0, 7'h7f, 1'b0};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        blink_en = 1'b0;
  logic [34:0] image = '1;
  logic [6:0]  rows;
  logic [4:0]  cols;
  logic        frame_done;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic        en;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[65];

  matrix_column_scanner #(
    .COLS(5), .ROWS(7), .SCAN_DIV(4), .BLANK_CYCLES(2), .BLINK_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .blink_en(blink_en),
    .image(image),
    .rows(rows),
    .cols(cols),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Expected {cols, rows, frame_done} t clocks after the scan starts:
  // 30-clock frames of five 6-clock columns, 2 blank then 4 drive.
  function automatic logic [12:0] model(int t, logic [6:0] pat, bit lit);
    int pos = t % 30;
    int p = pos % 6;
    logic [4:0] c = (p >= 2) ? 5'(1 << (pos / 6)) : 5'b0;
    logic [6:0] r = (p >= 2 && lit) ? pat : 7'h7f;
    logic fd = (t > 0 && pos == 0);
    return {c, r, fd};
  endfunction

  task automatic check(string name, logic [12:0] exp);
    n_checks++;
    if ({cols, rows, frame_done} !== exp) begin
      n_fail++;
      $display("FAIL %s: got cols=%b rows=%b fd=%b, expected cols=%b rows=%b fd=%b",
               name, cols, rows, frame_done, exp[12:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    @(negedge clock);
    check("reset_state", BLNK);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65; i++) tbl[i] = '{1'b1, model(i, PAT, 1'b1)};
    image = {5{PAT}};
    enable = 1'b1;
    @(negedge clock);
    restart();
    for (int i = 0; i < 65; i++) begin
      enable = tbl[i].en;
      cyc();
      check("scan", tbl[i].exp);
    end

    restart();
    image = '1;
    for (int t = 0; t < 60; t++) begin
      if (t == 10) image = '0;
      cyc();
      check("double_buffer", model(t, 7'h00, t >= 30));
    end

    restart();
    image = {5{PAT}};
    blink_en = 1'b1;
    for (int t = 0; t < 240; t++) begin
      int f;
      if (t == 185) blink_en = 1'b0;
      cyc();
      f = t / 30;
      check("blink", model(t, PAT, f inside {0, 1, 4, 5, 7}));
    end

    restart();
    for (int t = 0; t < 16; t++) begin
      cyc();
      check("pre_drop", model(t, PAT, 1'b1));
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("enable_drop", BLNK);
    end
    enable = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cyc();
      check("resume", model(t, PAT, 1'b1));
    end

    restart();
    for (int t = 0; t < 21; t++) begin
      cyc();
      check("pre_reset", model(t, PAT, 1'b1));
    end
    #2 reset_n = 1'b0;
    #1 check("async_reset", BLNK);
    #1 reset_n = 1'b1;
    for (int t = 0; t < 31; t++) begin
      cyc();
      check("post_reset", model(t, PAT, 1'b1));
    end

    restart();
    for (int t = 0; t < 30; t++) begin
      cyc();
      check("to_frame_end", model(t, PAT, 1'b1));
    end
    enable = 1'b0;
    cyc();
    check("late_drop", BLNK);
    cyc();
    check("late_idle", BLNK);
    enable = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
